// File: rtl/uart_duty_cmd_parser.sv
// Parses ASCII duty commands ('D'/'d', 1..MAX_DIGITS decimal digits, CR/LF) into the PWM duty register.
// Optional UART_DUTY_ACK_EN adds a one-entry 'K'/'E' response channel (tx_data/tx_valid/tx_ready).
module uart_duty_cmd_parser #(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] duty,
    output logic       duty_valid,
    output logic       cmd_error,
    output logic       busy
`ifdef UART_DUTY_ACK_EN
    ,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
`endif
);
    typedef enum logic [1:0] {IDLE, DIGITS, DISCARD} state_t;

    localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0]      MAX_CNT  = 2'(MAX_DIGITS);

    state_t          state_reg;
    logic [9:0]      acc_reg;
    logic [1:0]      cnt_reg;
    logic [TW-1:0]   tmo_reg;
    logic [7:0]      duty_reg;
    logic            duty_valid_reg;
    logic            cmd_error_reg;
    logic            busy_reg;

    logic            is_cmd;
    logic            is_term;
    logic            is_blank;
    logic            is_digit;
    logic            acc_ok;
    logic            tmo_hit;
    logic            accept_evt;
    logic            reject_evt;
    logic [9:0]      acc_step;

    // Command outcomes are decoded here so the ack channel can load on the same edge as the pulses.
    always_comb begin
        is_cmd     = (rx_data == 8'h44) || (rx_data == 8'h64);
        is_term    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_blank   = (rx_data == 8'h20);
        is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        acc_step   = acc_reg * 10'd10 + {6'd0, rx_data[3:0]};
        acc_ok     = (cnt_reg != 2'd0) && (acc_reg <= 10'd255);
        tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_reg == TMO_LAST);
        accept_evt = rx_valid && (state_reg == DIGITS) && is_term && acc_ok;
        if (rx_valid)
            reject_evt = is_term && ((state_reg == DISCARD) || ((state_reg == DIGITS) && !acc_ok));
        else
            reject_evt = (state_reg != IDLE) && tmo_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            tmo_reg        <= '0;
            duty_reg       <= '0;
            duty_valid_reg <= 1'b0;
            cmd_error_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            duty_valid_reg <= accept_evt;
            cmd_error_reg  <= reject_evt;
            if (accept_evt)
                duty_reg <= acc_reg[7:0];

            case (state_reg)
                IDLE: begin
                    tmo_reg <= '0;
                    if (rx_valid && is_cmd) begin
                        state_reg <= DIGITS;
                        busy_reg  <= 1'b1;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                    end else if (rx_valid && !is_term && !is_blank) begin
                        state_reg <= DISCARD;
                        busy_reg  <= 1'b1;
                    end
                end
                DIGITS: begin
                    if (rx_valid) begin
                        tmo_reg <= '0;
                        if (is_digit && (cnt_reg < MAX_CNT)) begin
                            acc_reg <= acc_step;
                            cnt_reg <= cnt_reg + 2'd1;
                        end else if (is_cmd) begin
                            acc_reg <= '0;
                            cnt_reg <= '0;
                        end else if (is_term) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            // one digit too many, or any stray character
                            state_reg <= DISCARD;
                        end
                    end else if (tmo_hit) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        tmo_reg   <= '0;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                DISCARD: begin
                    if (rx_valid) begin
                        tmo_reg <= '0;
                        if (is_term) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        tmo_reg   <= '0;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign duty       = duty_reg;
    assign duty_valid = duty_valid_reg;
    assign cmd_error  = cmd_error_reg;
    assign busy       = busy_reg;

`ifdef UART_DUTY_ACK_EN
    logic [7:0] tx_data_reg;
    logic       tx_valid_reg;

    // A fresh response replaces a pending one; tx_ready only drains when nothing new arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
        end else if (accept_evt) begin
            tx_data_reg  <= 8'h4B;
            tx_valid_reg <= 1'b1;
        end else if (reject_evt) begin
            tx_data_reg  <= 8'h45;
            tx_valid_reg <= 1'b1;
        end else if (tx_ready) begin
            tx_valid_reg <= 1'b0;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
`endif

endmodule

// File: tb/tb_uart_duty_cmd_parser.sv
// Self-checking bench for uart_duty_cmd_parser: directed scenarios plus random byte streams
// compared cycle by cycle against a command-buffer reference model.
module tb_uart_duty_cmd_parser;
    localparam int MAXD = 3;
    localparam int TMO  = 20;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] duty;
    logic       duty_valid;
    logic       cmd_error;
    logic       busy;
`ifdef UART_DUTY_ACK_EN
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: mode 0 idle, 1 collecting digits, 2 junk until terminator
    int         m_mode  = 0;
    logic [7:0] m_dig[$];
    int         m_quiet = 0;
    logic [7:0] m_duty  = 8'h00;
    logic       m_dv    = 1'b0;
    logic       m_err   = 1'b0;

    int dut_dv_cnt, dut_err_cnt, mdl_dv_cnt, mdl_err_cnt, cyc_mis, both_hi;

    uart_duty_cmd_parser #(
        .MAX_DIGITS    (MAXD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .duty      (duty),
        .duty_valid(duty_valid),
        .cmd_error (cmd_error),
        .busy      (busy)
`ifdef UART_DUTY_ACK_EN
        ,
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode  = 0;
        m_dig.delete();
        m_quiet = 0;
        m_duty  = 8'h00;
        m_dv    = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] b);
        int  val;
        logic term;
        term  = (b == 8'h0D) || (b == 8'h0A);
        m_dv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            m_quiet = 0;
            if (m_mode == 0) begin
                if (b == 8'h44 || b == 8'h64) begin
                    m_mode = 1;
                    m_dig.delete();
                end else if (!(term || b == 8'h20)) begin
                    m_mode = 2;
                end
            end else if (m_mode == 1) begin
                if (b >= 8'h30 && b <= 8'h39) begin
                    if (m_dig.size() < MAXD) m_dig.push_back(b - 8'h30);
                    else m_mode = 2;
                end else if (b == 8'h44 || b == 8'h64) begin
                    m_dig.delete();
                end else if (term) begin
                    val = 0;
                    foreach (m_dig[i]) val = val * 10 + int'(m_dig[i]);
                    if (m_dig.size() == 0 || val > 255) m_err = 1'b1;
                    else begin
                        m_duty = val[7:0];
                        m_dv   = 1'b1;
                    end
                    m_mode = 0;
                end else begin
                    m_mode = 2;
                end
            end else if (term) begin
                m_err  = 1'b1;
                m_mode = 0;
            end
        end else if (m_mode != 0) begin
            m_quiet++;
            if (m_quiet == TMO) begin
                m_err   = 1'b1;
                m_mode  = 0;
                m_quiet = 0;
            end
        end
    endfunction

    task automatic clear_counts();
        dut_dv_cnt = 0; dut_err_cnt = 0; mdl_dv_cnt = 0; mdl_err_cnt = 0;
        cyc_mis = 0; both_hi = 0;
    endtask

    task automatic tick(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        @(posedge clk);
        model_step(v, b);
        #1;
        rx_valid = 1'b0;
        if (duty_valid) dut_dv_cnt++;
        if (cmd_error) dut_err_cnt++;
        if (m_dv) mdl_dv_cnt++;
        if (m_err) mdl_err_cnt++;
        if (duty_valid && cmd_error) both_hi++;
        if (duty !== m_duty || duty_valid !== m_dv || cmd_error !== m_err || busy !== (m_mode != 0))
            cyc_mis++;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            tick(1'b1, s[i]);
            repeat (gap) tick(1'b0, 8'h00);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_counts();
        tick(1'b0, 8'h00);
        total++; if (duty !== 8'h00) begin bad++; $display("FAIL reset_duty got=%h want=00", duty); end
        total++; if (duty_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", duty_valid); end
        total++; if (cmd_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cmd_error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        send_str("D12", 0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy); end
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_async_busy got=%b want=0", busy); end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send_str("\015", 2);
        total++; if (dut_dv_cnt + dut_err_cnt !== 0) begin bad++; $display("FAIL mid_pulses got=%0d want=0", dut_dv_cnt + dut_err_cnt); end
        total++; if (cyc_mis !== 0) begin bad++; $display("FAIL mid_cycles got=%0d want=0", cyc_mis); end
    endtask

    task automatic test_basic();
        clear_counts();
        send_str("D128\015", 0);
        total++; if (duty !== 8'h80) begin bad++; $display("FAIL basic_duty got=%h want=80", duty); end
        total++; if (dut_dv_cnt !== 1) begin bad++; $display("FAIL basic_dv got=%0d want=1", dut_dv_cnt); end
        tick(1'b0, 8'h00);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy); end
        send_str("\012", 3);
        total++; if (dut_dv_cnt + dut_err_cnt !== 1) begin bad++; $display("FAIL basic_lf_pulses got=%0d want=1", dut_dv_cnt + dut_err_cnt); end
        total++; if (cyc_mis !== 0) begin bad++; $display("FAIL basic_cycles got=%0d want=0", cyc_mis); end
    endtask

    task automatic test_overflow();
        clear_counts();
        send_str("d256\012", 1);
        total++; if (dut_err_cnt !== 1) begin bad++; $display("FAIL ovf_err got=%0d want=1", dut_err_cnt); end
        total++; if (duty !== 8'h80) begin bad++; $display("FAIL ovf_duty got=%h want=80", duty); end
        send_str("D0\015", 0);
        total++; if (duty !== 8'h00 || dut_dv_cnt !== 1) begin bad++; $display("FAIL zero_cmd got=%h/%0d want=00/1", duty, dut_dv_cnt); end
        send_str("D255\015", 0);
        total++; if (duty !== 8'hFF || dut_dv_cnt !== 2) begin bad++; $display("FAIL max_cmd got=%h/%0d want=ff/2", duty, dut_dv_cnt); end
        send_str("D\015", 0);
        total++; if (dut_err_cnt !== 2) begin bad++; $display("FAIL empty_cmd got=%0d want=2", dut_err_cnt); end
        total++; if (cyc_mis !== 0) begin bad++; $display("FAIL ovf_cycles got=%0d want=0", cyc_mis); end
    endtask

    task automatic test_too_many();
        clear_counts();
        send_str("D1234\015", 0);
        total++; if (dut_err_cnt !== 1 || duty !== 8'hFF) begin bad++; $display("FAIL digits4 got=%0d/%h want=1/ff", dut_err_cnt, duty); end
        send_str("X\015", 0);
        total++; if (dut_err_cnt !== 2 || dut_dv_cnt !== 0) begin bad++; $display("FAIL junk got=%0d/%0d want=2/0", dut_err_cnt, dut_dv_cnt); end
        total++; if (cyc_mis !== 0) begin bad++; $display("FAIL junk_cycles got=%0d want=0", cyc_mis); end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_str("D5", 0);
        repeat (TMO - 1) tick(1'b0, 8'h00);
        total++; if (busy !== 1'b1 || dut_err_cnt !== 0) begin bad++; $display("FAIL tmo_early got=%b/%0d want=1/0", busy, dut_err_cnt); end
        tick(1'b0, 8'h00);
        total++; if (cmd_error !== 1'b1) begin bad++; $display("FAIL tmo_pulse got=%b want=1", cmd_error); end
        tick(1'b0, 8'h00);
        total++; if (busy !== 1'b0 || duty !== 8'hFF) begin bad++; $display("FAIL tmo_after got=%b/%h want=0/ff", busy, duty); end
        send_str("D5\015", TMO - 1);
        total++; if (duty !== 8'h05 || dut_dv_cnt !== 1) begin bad++; $display("FAIL tmo_gap got=%h/%0d want=05/1", duty, dut_dv_cnt); end
        send_str("Z", TMO);
        total++; if (dut_err_cnt !== 2 || busy !== 1'b0) begin bad++; $display("FAIL tmo_discard got=%0d/%b want=2/0", dut_err_cnt, busy); end
        total++; if (cyc_mis !== 0) begin bad++; $display("FAIL tmo_cycles got=%0d want=0", cyc_mis); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_str("D12\015D34\012d7\015 dD9\015", 0);
        total++; if (dut_dv_cnt !== 4 || duty !== 8'h09) begin bad++; $display("FAIL b2b got=%0d/%h want=4/09", dut_dv_cnt, duty); end
        total++; if (cyc_mis !== 0) begin bad++; $display("FAIL b2b_cycles got=%0d want=0", cyc_mis); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r, gap;
        clear_counts();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            if (r <= 7 || r == 15) b = 8'h30 + 8'($urandom_range(0, 9));
            else if (r == 8) b = 8'h44;
            else if (r == 9) b = 8'h64;
            else if (r == 10 || r == 14) b = 8'h0D;
            else if (r == 11) b = 8'h0A;
            else if (r == 12) b = 8'h20;
            else b = 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 70) gap = 0;
            else if (r < 95) gap = $urandom_range(1, 5);
            else gap = $urandom_range(TMO - 2, TMO + 2);
            tick(1'b1, b);
            repeat (gap) tick(1'b0, 8'h00);
        end
        total++; if (cyc_mis !== 0) begin bad++; $display("FAIL rnd_cycles got=%0d want=0", cyc_mis); end
        total++; if (dut_dv_cnt !== mdl_dv_cnt) begin bad++; $display("FAIL rnd_dv got=%0d want=%0d", dut_dv_cnt, mdl_dv_cnt); end
        total++; if (dut_err_cnt !== mdl_err_cnt) begin bad++; $display("FAIL rnd_err got=%0d want=%0d", dut_err_cnt, mdl_err_cnt); end
        total++; if (duty !== m_duty) begin bad++; $display("FAIL rnd_duty got=%h want=%h", duty, m_duty); end
        total++; if (both_hi !== 0) begin bad++; $display("FAIL rnd_exclusive got=%0d want=0", both_hi); end
    endtask

`ifdef UART_DUTY_ACK_EN
    task automatic test_ack();
        tx_ready = 1'b0;
        send_str("D9\015", 0);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin bad++; $display("FAIL ack_k got=%b/%h want=1/4b", tx_valid, tx_data); end
        send_str("Q\015", 1);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin bad++; $display("FAIL ack_e got=%b/%h want=1/45", tx_valid, tx_data); end
        tx_ready = 1'b1;
        tick(1'b0, 8'h00);
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL ack_drain got=%b want=0", tx_valid); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_too_many();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_DUTY_ACK_EN
        test_ack();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
